// File: rtl/m_principal.sv
// 256x8 single-port RAM with identity reset contents and new-data read-during-write.
// Define M_PRINCIPAL_OUTREG_EN to add an output pipeline register (read latency 2).
module m_principal (
  input  logic [7:0] address,
  input  logic       clock,
  input  logic [7:0] data,
  input  logic       wren,
  output logic [7:0] q,
  input  logic       reset_n
);

  localparam int unsigned AW    = 8;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 1 << AW;

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rd_d;
  logic [DW-1:0] rd_q;

  // Write port bypasses the array so a write edge returns the new data.
  always_comb begin
    rd_d = mem_q[address];
    if (wren) rd_d = data;
  end

  // Array and first read stage; reset reloads the identity pattern.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned a = 0; a < DEPTH; a++) mem_q[a] <= DW'(a);
      rd_q <= '0;
    end else begin
      if (wren) mem_q[address] <= data;
      rd_q <= rd_d;
    end
  end

`ifdef M_PRINCIPAL_OUTREG_EN
  logic [DW-1:0] out_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) out_q <= '0;
    else          out_q <= rd_q;
  end

  assign q = out_q;
`else
  assign q = rd_q;
`endif

endmodule

// File: tb/tb_m_principal.sv
// Self-checking bench for m_principal: directed scenarios plus random accesses
// compared against an array-and-history reference model.
module tb_m_principal;

`ifdef M_PRINCIPAL_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic [7:0] address;
  logic       clock;
  logic [7:0] data;
  logic       wren;
  logic [7:0] q;
  logic       reset_n = 1'b1;

  int n_pass  = 0;
  int n_total = 0;

  logic [7:0] mdl [256];
  logic [7:0] hist [$];

  m_principal dut (
    .address (address),
    .clock   (clock),
    .data    (data),
    .wren    (wren),
    .q       (q),
    .reset_n (reset_n)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int a = 0; a < 256; a++) mdl[a] = 8'(a);
    hist.delete();
    for (int i = 0; i < LAT; i++) hist.push_back(8'h00);
  endtask

  // One access: drive between edges, advance one edge, compare q at its latency.
  task automatic step(input string tag, input logic [7:0] a, input logic [7:0] d, input logic we);
    logic [7:0] rd;
    address = a;
    data    = d;
    wren    = we;
    @(posedge clock);
    rd = we ? d : mdl[a];
    if (we) mdl[a] = d;
    hist.push_back(rd);
    #1;
    chk(tag, q, hist[hist.size() - LAT]);
  endtask

  // Assert reset between edges, pulse a write while held, release at a negedge.
  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    chk("rst_immediate_q", q, 8'h00);
    address = 8'h20;
    data    = 8'hEE;
    wren    = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    wren    = 1'b0;
    address = 8'h00;
    reset_n = 1'b1;
    model_reset();
    #1;
    chk("rst_release_q", q, 8'h00);
  endtask

  initial begin
    address = '0;
    data    = '0;
    wren    = 1'b0;
    #2;
    do_reset();

    step("rd05", 8'h05, 8'h00, 1'b0);
    step("rdFF", 8'hFF, 8'h00, 1'b0);
    step("rd00", 8'h00, 8'h00, 1'b0);
    chk("rd05_value", hist[hist.size() - 3], 8'h05);

    step("wr02_new", 8'h02, 8'hA5, 1'b1);
    step("rd02",     8'h02, 8'h00, 1'b0);
    step("rd03",     8'h03, 8'h00, 1'b0);

    step("wr80_11", 8'h80, 8'h11, 1'b1);
    step("wr80_22", 8'h80, 8'h22, 1'b1);
    step("rd80",    8'h80, 8'h00, 1'b0);
    step("rd7F",    8'h7F, 8'h00, 1'b0);
    step("rd81",    8'h81, 8'h00, 1'b0);
    step("rd81_b",  8'h81, 8'h00, 1'b0);
    chk("mdl80", mdl[8'h80], 8'h22);

    step("wr10", 8'h10, 8'h3C, 1'b1);
    do_reset();
    step("rd10_after_rst", 8'h10, 8'h00, 1'b0);
    step("rd20_gated",     8'h20, 8'h00, 1'b0);
    step("rd02_identity",  8'h02, 8'h00, 1'b0);

    // Random accesses on a small address window to force collisions.
    for (int i = 0; i < 400; i++) begin
      logic [7:0] a;
      a = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7));
      step("rand", a, 8'($urandom), 1'($urandom));
    end

    for (int a = 0; a < 256; a++) step("sweep_wr", 8'(a), ~8'(a), 1'b1);
    for (int a = 0; a < 256; a++) step("sweep_rd", 8'(a), 8'h00, 1'b0);
    step("sweep_flush", 8'h00, 8'h00, 1'b0);
    chk("sweep_mdl_last", mdl[255], 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
